// File: rtl/multi_pulse_sync.sv
// -----------------------------------------------------------------------------
// multi_pulse_sync
//
// N-channel receiver for events that come from an unrelated clock domain. For
// each channel the input is synchronised, edge-detected, and every detected
// edge is queued in a saturating pending counter. Local logic drains the
// queued events over a per-channel valid/ready handshake, so the consumer can
// stall without losing events (up to 2**CNT_W-1 of them per channel).
//
// Handshake: evt_valid[i] is high while channel i holds at least one pending
// event. One event is consumed on every clk edge where evt_valid[i] and
// evt_ready[i] are both high. evt_ready[i] is ignored while evt_valid[i] is
// low, and may be tied high.
//
// Optional feature macro: MULTI_PULSE_SYNC_FILTER_EN
//   When defined, a per-channel glitch filter sits after the synchroniser. The
//   filtered level only follows the synchronised level once that level has
//   been stable for FILT_CYC consecutive cycles. Latency grows by FILT_CYC.
//   When undefined, FILT_CYC is unused.
//
// Ports:
//   clk        in   1            sole clock
//   rst_n      in   1            asynchronous active-low reset
//   evt_in     in   N_CH         asynchronous event inputs (level/toggle)
//   evt_valid  out  N_CH         channel has one or more pending events
//   evt_ready  in   N_CH         consumer accepts one event when valid&ready
//   evt_ovf    out  N_CH         sticky: an edge arrived while saturated
//   ovf_clr    in   1            pulse clears all evt_ovf bits
//   pend_cnt   out  N_CH*CNT_W   pending counts, channel 0 in the LSBs
// -----------------------------------------------------------------------------
module multi_pulse_sync #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 3,
    parameter int FILT_CYC    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       evt_in,
    output logic [N_CH-1:0]       evt_valid,
    input  logic [N_CH-1:0]       evt_ready,
    output logic [N_CH-1:0]       evt_ovf,
    input  logic                  ovf_clr,
    output logic [N_CH*CNT_W-1:0] pend_cnt
);

    // The history flop must settle on the (possibly filtered) level seen at
    // reset release before edges are trusted, otherwise an input that is
    // already high would look like a rising edge.
`ifdef MULTI_PULSE_SYNC_FILTER_EN
    localparam int PRIME_LEN = SYNC_STAGES + 1 + FILT_CYC;
`else
    localparam int PRIME_LEN = SYNC_STAGES + 1;
`endif
    localparam int PRIME_W = $clog2(PRIME_LEN + 1);
    localparam logic [PRIME_W-1:0] PRIME_END = PRIME_LEN[PRIME_W-1:0];
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

    // ------------------------------------------------------------------
    // Prime counter: counts clk edges after reset release, then holds.
    // ------------------------------------------------------------------
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prime_cnt <= '0;
        end else if (prime_cnt != PRIME_END) begin
            prime_cnt <= prime_cnt + 1'b1;
        end
    end

    assign primed = (prime_cnt == PRIME_END);

    // ------------------------------------------------------------------
    // Synchroniser chain, all channels in parallel.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q [SYNC_STAGES];
    logic [N_CH-1:0] sync_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= evt_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_lvl = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Level used for edge detection (filtered or straight from the chain).
    // ------------------------------------------------------------------
    logic [N_CH-1:0] lvl;

`ifdef MULTI_PULSE_SYNC_FILTER_EN
    localparam int FC_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILT_CYC - 1);

    logic [N_CH-1:0] filt_q;
    logic [FC_W-1:0] filt_cnt [N_CH];

    // filt_cnt counts consecutive cycles in which the synchronised level
    // differs from the filtered level; any return to agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                filt_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sync_lvl[i] == filt_q[i]) begin
                    filt_cnt[i] <= '0;
                end else if (filt_cnt[i] == FC_LAST) begin
                    filt_q[i]   <= sync_lvl[i];
                    filt_cnt[i] <= '0;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_lvl;
`endif

    // ------------------------------------------------------------------
    // Edge detection.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] hist_q;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= lvl;
        end
    end

    assign rise = lvl & ~hist_q;
    assign fall = ~lvl & hist_q;

    always_comb begin
        edge_det = '0;
        case (EDGE_MODE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase
        edge_det = edge_det & {N_CH{primed}};
    end

    // ------------------------------------------------------------------
    // Pending counters and sticky overflow flags.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];
    logic [N_CH-1:0]  ovf_q;
    logic [N_CH-1:0]  ovf_d;
    logic [N_CH-1:0]  inc;
    logic [N_CH-1:0]  dec;

    assign inc = edge_det;
    assign dec = evt_valid & evt_ready;

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            // Clear first so that a saturating edge in the same cycle wins.
            ovf_d[i] = ovf_q[i] & ~ovf_clr;
            if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ovf_q <= ovf_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived directly from registered state.
    // ------------------------------------------------------------------
    always_comb begin
        evt_valid = '0;
        pend_cnt  = '0;
        for (int i = 0; i < N_CH; i++) begin
            evt_valid[i]                 = |cnt_q[i];
            pend_cnt[i*CNT_W +: CNT_W]   = cnt_q[i];
        end
    end

    assign evt_ovf = ovf_q;

endmodule
